// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer: widths, opcodes
// and the sequencer FSM state encoding.
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_OPC_W  = 3;

  localparam logic [ALU_OPC_W-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OPC_W-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_OPC_W-1:0] OP_NOT = 3'd2;
  localparam logic [ALU_OPC_W-1:0] OP_AND = 3'd3;
  localparam logic [ALU_OPC_W-1:0] OP_OR  = 3'd4;
  localparam logic [ALU_OPC_W-1:0] OP_XOR = 3'd5;
  localparam logic [ALU_OPC_W-1:0] OP_SHL = 3'd6;
  localparam logic [ALU_OPC_W-1:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of command, response and ALU-drive signals around alu_sequencer.
// Optional rsp_zero/rsp_neg flags exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_sequencer_if #(
  parameter int DATA_W  = 8,
  parameter int OPC_W   = 3,
  parameter int COUNT_W = 16
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and payload is held until the transfer.
  logic               cmd_valid;
  logic               cmd_ready;
  logic [OPC_W-1:0]   cmd_opcode;
  logic [DATA_W-1:0]  cmd_op1;
  logic [DATA_W-1:0]  cmd_op2;
  logic               cmd_use_acc;
  logic               acc_clr;

  logic [OPC_W-1:0]   alu_opcode;
  logic [DATA_W-1:0]  alu_operand1;
  logic [DATA_W-1:0]  alu_operand2;
  logic [DATA_W-1:0]  alu_result;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_data;
  logic [OPC_W-1:0]   rsp_opcode;
  logic [DATA_W-1:0]  acc;
  logic [COUNT_W-1:0] op_count;

`ifdef ALU_SEQ_FLAGS_EN
  logic               rsp_zero;
  logic               rsp_neg;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_use_acc, acc_clr,
    input  alu_result, rsp_ready,
    output cmd_ready, alu_opcode, alu_operand1, alu_operand2,
    output rsp_valid, rsp_data, rsp_opcode, acc, op_count, rsp_zero, rsp_neg
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_use_acc, acc_clr,
    output alu_result, rsp_ready,
    input  cmd_ready, alu_opcode, alu_operand1, alu_operand2,
    input  rsp_valid, rsp_data, rsp_opcode, acc, op_count, rsp_zero, rsp_neg
  );
`else
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_use_acc, acc_clr,
    input  alu_result, rsp_ready,
    output cmd_ready, alu_opcode, alu_operand1, alu_operand2,
    output rsp_valid, rsp_data, rsp_opcode, acc, op_count
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_use_acc, acc_clr,
    output alu_result, rsp_ready,
    input  cmd_ready, alu_opcode, alu_operand1, alu_operand2,
    input  rsp_valid, rsp_data, rsp_opcode, acc, op_count
  );
`endif

endinterface

// File: rtl/alu_sequencer.sv
// Command-side driver for the external 8-op ALU: IDLE -> EXEC -> RESP, with an
// accumulator and saturating op counter. ALU_SEQ_FLAGS_EN adds zero/neg flags.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OPC_W   = ALU_OPC_W,
  parameter int COUNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus,
  output alu_seq_state_e  o_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]         r_state;
  logic [OPC_W-1:0]   r_alu_opcode;
  logic [DATA_W-1:0]  r_alu_operand1;
  logic [DATA_W-1:0]  r_alu_operand2;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [OPC_W-1:0]   r_rsp_opcode;
  logic [DATA_W-1:0]  r_acc;
  logic [COUNT_W-1:0] r_op_count;

  logic w_accept;
  logic w_capture;
  logic w_handshake;
  logic w_count_max;

  assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_capture   = (r_state == S_EXEC);
  assign w_handshake = (r_state == S_RESP) && bus.rsp_ready;
  assign w_count_max = &r_op_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.cmd_valid) r_state <= S_EXEC;
        S_EXEC:  r_state <= S_RESP;
        S_RESP:  if (bus.rsp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Drive registers keep their last command between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_opcode   <= '0;
      r_alu_operand1 <= '0;
      r_alu_operand2 <= '0;
    end else if (w_accept) begin
      r_alu_opcode   <= bus.cmd_opcode;
      r_alu_operand1 <= bus.cmd_use_acc ? r_acc : bus.cmd_op1;
      r_alu_operand2 <= bus.cmd_op2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_opcode <= '0;
    end else if (w_capture) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_data   <= bus.alu_result;
      r_rsp_opcode <= r_alu_opcode;
    end else if (w_handshake) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  // A clear on the capture edge beats the new result.
  always_ff @(posedge clk) begin
    if (rst || bus.acc_clr) begin
      r_acc <= '0;
    end else if (w_capture) begin
      r_acc <= bus.alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_handshake && !w_count_max) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic r_rsp_zero;
  logic r_rsp_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_zero <= 1'b0;
      r_rsp_neg  <= 1'b0;
    end else if (w_capture) begin
      r_rsp_zero <= (bus.alu_result == '0);
      r_rsp_neg  <= bus.alu_result[DATA_W-1];
    end
  end

  assign bus.rsp_zero = r_rsp_zero;
  assign bus.rsp_neg  = r_rsp_neg;
`endif

  assign bus.cmd_ready    = (r_state == S_IDLE);
  assign bus.alu_opcode   = r_alu_opcode;
  assign bus.alu_operand1 = r_alu_operand1;
  assign bus.alu_operand2 = r_alu_operand2;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_opcode   = r_rsp_opcode;
  assign bus.acc          = r_acc;
  assign bus.op_count     = r_op_count;
  assign o_state          = alu_seq_state_e'(r_state);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-op ALU on the alu_* side.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int DATA_W  = 8;
  localparam int OPC_W   = 3;
  localparam int COUNT_W = 4;

  logic           clk;
  logic           rst;
  alu_seq_state_e state;

  alu_sequencer_if #(.DATA_W(DATA_W), .OPC_W(OPC_W), .COUNT_W(COUNT_W)) bus ();

  alu_sequencer #(.DATA_W(DATA_W), .OPC_W(OPC_W), .COUNT_W(COUNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: shifts are by one, operand2 unused for not/shl/shr.
  function automatic logic [DATA_W-1:0] alu_model(input logic [OPC_W-1:0] opc,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    case (opc)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_NOT:  return ~a;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  always_comb bus.alu_result = alu_model(bus.alu_opcode, bus.alu_operand1, bus.alu_operand2);

  int n_tests = 0;
  int n_fail  = 0;
  int exp_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: issue one command from IDLE, run it through, handshake immediately.
  task automatic do_op(input string tag, input logic [OPC_W-1:0] opc,
                       input logic [DATA_W-1:0] op1, input logic [DATA_W-1:0] op2,
                       input logic use_acc, input logic [DATA_W-1:0] exp_res);
    int k;
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = opc;
    bus.cmd_op1     = op1;
    bus.cmd_op2     = op2;
    bus.cmd_use_acc = use_acc;
    bus.rsp_ready   = 1'b0;
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
    chk({tag, "_alu_opc"}, bus.alu_opcode, opc);
    k = 0;
    while (!bus.rsp_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, "_rsp_data"}, bus.rsp_data, exp_res);
    chk({tag, "_rsp_opc"}, bus.rsp_opcode, opc);
    chk({tag, "_acc"}, bus.acc, exp_res);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    if (exp_count < 15) exp_count++;
    chk({tag, "_count"}, bus.op_count, exp_count);
    chk({tag, "_valid_drop"}, bus.rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
  end

  initial begin
    int n_exec;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_op1 = '0; bus.cmd_op2 = '0;
    bus.cmd_use_acc = 1'b0; bus.acc_clr = 1'b0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_state", state, IDLE);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_alu_drive", {bus.alu_opcode, bus.alu_operand1, bus.alu_operand2}, 0);
    chk("rst_acc_count", {bus.acc, bus.op_count}, 0);
    rst = 1'b0;

    // Test 1: ADD 5+3 with latency checks
    bus.cmd_valid = 1'b1; bus.cmd_opcode = OP_ADD; bus.cmd_op1 = 8'h05; bus.cmd_op2 = 8'h03;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("t1_exec_state", state, EXEC);
    chk("t1_exec_ready", bus.cmd_ready, 1'b0);
    chk("t1_exec_valid", bus.rsp_valid, 1'b0);
    chk("t1_operands", {bus.alu_operand1, bus.alu_operand2}, 16'h0503);
    @(negedge clk);
    chk("t1_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t1_rsp_data", bus.rsp_data, 8'h08);
    chk("t1_rsp_opc", bus.rsp_opcode, OP_ADD);
    chk("t1_acc", bus.acc, 8'h08);
    chk("t1_count_pre", bus.op_count, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_count = 1;
    chk("t1_count", bus.op_count, 1);
    chk("t1_idle_ready", bus.cmd_ready, 1'b1);

    // Test 2: accumulator chaining and wrap
    bus.cmd_valid = 1'b1; bus.cmd_opcode = OP_SUB; bus.cmd_op1 = 8'hFF; bus.cmd_op2 = 8'h02;
    bus.cmd_use_acc = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_use_acc = 1'b0;
    chk("t2_operand1_acc", bus.alu_operand1, 8'h08);
    @(negedge clk);
    chk("t2_rsp_data", bus.rsp_data, 8'h06);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_count = 2;
    do_op("t2_wrap", OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF);
`ifdef ALU_SEQ_FLAGS_EN
    chk("t2_neg", bus.rsp_neg, 1'b1);
    chk("t2_zero", bus.rsp_zero, 1'b0);
`endif

    // Test 3: backpressure with a competing command
    bus.cmd_valid = 1'b1; bus.cmd_opcode = OP_AND; bus.cmd_op1 = 8'hF3; bus.cmd_op2 = 8'h3C;
    @(negedge clk);
    bus.cmd_opcode = OP_SHL; bus.cmd_op1 = 8'h81; bus.cmd_op2 = 8'h55;
    @(negedge clk);
    chk("t3_first_valid", bus.rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_data", bus.rsp_data, 8'h30);
      chk("t3_hold_ready", bus.cmd_ready, 1'b0);
      chk("t3_hold_drive", bus.alu_opcode, OP_AND);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_count = 4;
    chk("t3_hs_count", bus.op_count, 4);
    chk("t3_not_taken", bus.alu_opcode, OP_AND);
    chk("t3_back_idle", state, IDLE);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("t3_second_opnd", bus.alu_operand1, 8'h81);
    @(negedge clk);
    chk("t3_second_data", bus.rsp_data, 8'h02);
    chk("t3_second_opc", bus.rsp_opcode, OP_SHL);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_count = 5;
    chk("t3_count", bus.op_count, 5);

    // Test 4: reset during EXEC
    bus.cmd_valid = 1'b1; bus.cmd_opcode = OP_XOR; bus.cmd_op1 = 8'hF0; bus.cmd_op2 = 8'h0F;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("t4_exec", state, EXEC);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_state", state, IDLE);
    chk("t4_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_opcode}, 0);
    chk("t4_drive", {bus.alu_opcode, bus.alu_operand1, bus.alu_operand2}, 0);
    chk("t4_acc_count", {bus.acc, bus.op_count}, 0);
    chk("t4_ready", bus.cmd_ready, 1'b1);
    @(negedge clk);
    chk("t4_no_rsp", bus.rsp_valid, 1'b0);
    exp_count = 0;

    // Test 5: acc_clr on capture edge, and with use_acc at accept
    do_op("t5_pre", OP_ADD, 8'h11, 8'h22, 1'b0, 8'h33);
    bus.cmd_valid = 1'b1; bus.cmd_opcode = OP_OR; bus.cmd_op1 = 8'h0C; bus.cmd_op2 = 8'h30;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    chk("t5_rsp_data", bus.rsp_data, 8'h3C);
    chk("t5_acc_clr", bus.acc, 8'h00);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_count = 2;
    do_op("t5_load", OP_ADD, 8'h05, 8'h10, 1'b0, 8'h15);
    bus.cmd_valid = 1'b1; bus.cmd_opcode = OP_ADD; bus.cmd_op2 = 8'h01;
    bus.cmd_use_acc = 1'b1; bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_use_acc = 1'b0; bus.acc_clr = 1'b0;
    chk("t5_preclr_opnd", bus.alu_operand1, 8'h15);
    chk("t5_clr_idle", bus.acc, 8'h00);
    @(negedge clk);
    chk("t5_chain_data", bus.rsp_data, 8'h16);
    chk("t5_chain_acc", bus.acc, 8'h16);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_count = 4;

    // Throughput: back-to-back NOT with both sides always ready
    bus.cmd_valid = 1'b1; bus.cmd_opcode = OP_NOT; bus.cmd_op1 = 8'h0F; bus.rsp_ready = 1'b1;
    n_exec = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (state == EXEC) n_exec++;
    end
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    chk("tp_exec_cycles", n_exec, 3);
    chk("tp_acc", bus.acc, 8'hF0);
    exp_count = 7;
    chk("tp_count", bus.op_count, 7);

    // Test 6: counter saturation at 15 over 20 total operations
    for (int i = 0; i < 13; i++) begin
      do_op("t6_op", OP_ADD, i[7:0], 8'h01, 1'b0, i[7:0] + 8'h01);
    end
    chk("t6_saturated", bus.op_count, 4'hF);
`ifdef ALU_SEQ_FLAGS_EN
    do_op("t6_zero", OP_XOR, 8'h5A, 8'h5A, 1'b0, 8'h00);
    chk("t6_zero_flag", bus.rsp_zero, 1'b1);
    chk("t6_neg_flag", bus.rsp_neg, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
